// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous memory between CPU fetch, CPU data and a host port.
// Data beats fetch unless fetch has starved; the host takes the memory exclusively via a lock FSM.
module mem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          h_lock_req,
  output logic          h_lock_ack,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {RUN, DRAIN, HOST} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       i_rvalid_q, i_rvalid_d;
  logic       d_rvalid_q, d_rvalid_d;
  logic       h_rvalid_q, h_rvalid_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      starve_q   <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    h_gnt    = 1'b0;
    case (state_q)
      RUN: begin
        if (h_lock_req) begin
          state_d = DRAIN;
        end else if (i_req && starve_q == LIMIT) begin
          i_gnt = 1'b1;
        end else if (d_req) begin
          d_gnt = 1'b1;
        end else if (i_req) begin
          i_gnt = 1'b1;
        end
        // Counter only moves in RUN; the lock path freezes it.
        if (!i_req || i_gnt)       starve_d = '0;
        else if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
      end
      DRAIN: state_d = h_lock_req ? HOST : RUN;
      HOST: begin
        h_gnt = h_req & h_lock_req;
        if (!h_lock_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (reset) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      h_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt | h_gnt;
    mem_we    = (d_gnt & d_we) | (h_gnt & h_we);
    mem_addr  = i_addr;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (h_gnt) begin
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end
    i_rvalid_d = i_gnt;
    d_rvalid_d = d_gnt & ~d_we;
    h_rvalid_d = h_gnt & ~h_we;
  end

  assign h_lock_ack = (state_q == HOST);
  assign i_rvalid   = i_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign h_rvalid   = h_rvalid_q;
  assign i_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;
  assign h_rdata    = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 256x16 synchronous memory among three requesters: the CPU instruction-fetch port, the CPU data port, and a host loader/debug port.
- Per-cycle fixed-priority arbitration with starvation protection for fetch.
- Lock FSM hands the memory exclusively to the host for program load or inspection.
- Sits between the pipelined CPU core and the unified memory macro.

Parameters:
- AW, 8, address width
- DW, 16, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  DW  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DW  data read data
- h_lock_req  in  1  host requests exclusive ownership; level
- h_lock_ack  out  1  host owns memory (registered)
- h_req, h_we, h_addr, h_wdata  in  1/1/AW/DW  host access, same rules as d_*
- h_gnt, h_rvalid, h_rdata  out  1/1/DW  host grant / read return
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en & !mem_we

Behaviour:
- Reset is synchronous. While reset = 1:
  - all *_gnt, mem_en and mem_we are forced to 0.
  - On the clock edge: state <= RUN, starve_cnt <= 0, h_lock_ack <= 0, all *_rvalid <= 0.
  - Reset mid-access abandons the pending read; no rvalid is issued for it.
- FSM states RUN, DRAIN, HOST:
  - RUN: if h_lock_req = 1, no CPU grant this cycle and next state is DRAIN. Otherwise arbitrate i/d.
  - DRAIN: no grants. Exactly one cycle, which lets the last outstanding read return. Next state is HOST if h_lock_req = 1, else RUN.
  - HOST: h_lock_ack = 1; i_gnt = d_gnt = 0; h_gnt = h_req & h_lock_req. When h_lock_req = 0, next state is RUN and h_lock_ack falls next cycle. Lock drop beats a same-cycle h_req: no grant.
- h_lock_ack is registered: it is 1 exactly while state == HOST.
- h_gnt is 0 outside HOST.
- RUN arbitration:
  - d wins over i, except i wins when i_req = 1 and starve_cnt == STARVE_LIMIT.
  - At most one grant per cycle.
- starve_cnt (4 bits, saturating at STARVE_LIMIT):
  - cleared on i_gnt or when i_req = 0;
  - incremented when i_req & !i_gnt in RUN;
  - held in DRAIN and HOST.
- Granted cycle drives memory combinationally from the winner: mem_en = 1, mem_addr, mem_we (0 for fetch), mem_wdata.
- Read latency is 1 cycle:
  - X_rvalid <= X_gnt & !X_we (fetch is always a read).
  - i_rdata, d_rdata and h_rdata all equal mem_rdata.
  - Writes produce no rvalid and complete in the grant cycle.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Address wrap is not applicable: addresses are passed through unmodified.

Test Plan:
- Fetch only: i_req with i_addr = 0x10, mem[0x10] = 0x1234 -> i_gnt same cycle, mem_en = 1, mem_addr = 0x10; next cycle i_rvalid = 1, i_rdata = 0x1234; d_rvalid = 0.
- Contention: i_req and d_req held high, d_we = 0, STARVE_LIMIT = 4 -> d granted cycles 0-3, i granted cycle 4, starve_cnt returns to 0, d granted cycle 5.
- Data write then read: d write 0xBEEF to 0x20, then d read of 0x20 -> mem_we = 1 only in the write cycle, no rvalid for the write; d_rvalid = 1 with d_rdata = 0xBEEF one cycle after the read grant.
- Host lock:
  - Raise h_lock_req in cycle N during CPU traffic -> no CPU grant in N or N+1 (DRAIN); h_lock_ack = 1 from N+2.
  - Host write 0x4000 to 0x00 -> h_gnt, mem_we = 1.
  - Drop h_lock_req -> no grant that cycle; h_lock_ack = 0 next cycle and CPU grants resume.
- Aborted lock: h_lock_req pulsed for only 1 cycle -> FSM goes RUN -> DRAIN -> RUN, h_lock_ack stays 0.
- Reset in HOST with a host read in flight -> next cycle state is RUN, h_lock_ack = 0, h_rvalid = 0, starve_cnt = 0, and no grants while reset is high.
